// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the imem port arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, RESP} arb_state_t;

  localparam int unsigned REQ_FETCH = 0;
  localparam int unsigned REQ_DEBUG = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, prio breaks ties.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant,
  output logic       any
);

  always_comb begin
    grant = 1'b0;
    if (valid == 2'b11) begin
      grant = prio;
    end else if (valid[1]) begin
      grant = 1'b1;
    end
    any = |valid;
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the combinational imem read port between fetch (port 0) and debug (port 1).
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  output logic [1:0]    req_ready,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_q
);

  arb_state_t    state_q, state_d;
  logic          prio_q;
  logic          owner_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  data_q;
  logic          grant;
  logic          any;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .prio  (prio_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          req_ready[grant] = 1'b1;
          state_d          = READ;
        end
      end
      READ: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address and data are registered so the outputs stay stable across states.
  assign mem_addr = addr_q;
  assign rsp_data = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any) begin
        addr_q  <= grant ? req_addr1 : req_addr0;
        owner_q <= grant;
        prio_q  <= ~grant;
      end
      if (state_q == READ) begin
        data_q <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-free reference.
module tb_imem_port_arbiter;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [N-1:0]  rsp_data;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_q;

  logic [N-1:0]  golden [64];
  int            total = 0;
  int            bad   = 0;
  int            last_served;

  always #5 clk = ~clk;

  assign mem_q = golden[mem_addr];

  imem_port_arbiter #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a lone requester wins; on contention the side not served last wins.
  function automatic int winner(input logic [1:0] v);
    if (v == 2'b11) return 1 - last_served;
    return v[1] ? 1 : 0;
  endfunction

  task automatic txn(input string tag, input logic [1:0] v, input logic [AW-1:0] a0,
                     input logic [AW-1:0] a1, input int stall);
    int            w;
    logic [AW-1:0] a;
    logic [1:0]    oh;
    w  = winner(v);
    a  = (w == 1) ? a1 : a0;
    oh = (w == 1) ? 2'b10 : 2'b01;
    req_valid = v;
    req_addr0 = a0;
    req_addr1 = a1;
    rsp_ready = 2'b00;
    #1;
    chk({tag, ".req_ready"}, N'(req_ready), N'(oh));
    chk({tag, ".idle_rsp_valid"}, N'(rsp_valid), '0);
    tick();
    last_served = w;
    req_valid   = 2'b00;
    #1;
    chk({tag, ".read_req_ready"}, N'(req_ready), '0);
    chk({tag, ".read_mem_addr"}, N'(mem_addr), N'(a));
    tick();
    chk({tag, ".rsp_valid"}, N'(rsp_valid), N'(oh));
    chk({tag, ".rsp_data"}, rsp_data, golden[a]);
    for (int i = 0; i < stall; i++) begin
      // Non-owner rsp_ready and new requests must both be ignored while holding.
      rsp_ready = ~oh;
      req_valid = 2'($urandom_range(1, 3));
      tick();
      chk({tag, ".hold_rsp_valid"}, N'(rsp_valid), N'(oh));
      chk({tag, ".hold_rsp_data"}, rsp_data, golden[a]);
      chk({tag, ".hold_req_ready"}, N'(req_ready), '0);
    end
    req_valid = 2'b00;
    rsp_ready = oh;
    tick();
    rsp_ready = 2'b00;
    #1;
    chk({tag, ".back_idle_rsp_valid"}, N'(rsp_valid), '0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) golden[i] = $urandom;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_addr0 = '0;
    req_addr1 = '0;
    rsp_ready = 2'b00;
    last_served = 1;

    // 1) reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.req_ready", N'(req_ready), '0);
      chk("rst.rsp_valid", N'(rsp_valid), '0);
      chk("rst.mem_addr", N'(mem_addr), '0);
      chk("rst.rsp_data", rsp_data, '0);
    end
    reset = 1'b0;
    tick();
    chk("post_rst.rsp_valid", N'(rsp_valid), '0);

    // 2) single fetch request
    txn("p0_addr5", 2'b01, 6'd5, 6'd0, 0);

    // 3) collision right after reset, then port 1, then collision again
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_served = 1;
    txn("coll_first", 2'b11, 6'd1, 6'd2, 0);
    txn("coll_second", 2'b10, 6'd1, 6'd2, 0);
    txn("coll_again", 2'b11, 6'd1, 6'd2, 0);

    // 4) sustained contention alternates
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("alt%0d", i), 2'b11, 6'($urandom), 6'($urandom), 0);
    end

    // 5) top address with a long stall on port 1
    txn("p1_addr63_stall", 2'b10, 6'd0, 6'd63, 10);

    // 6) reset during READ drops the read
    req_valid = 2'b01;
    req_addr0 = 6'd7;
    tick();
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_read.rsp_valid", N'(rsp_valid), '0);
    chk("rst_read.req_ready", N'(req_ready), '0);
    tick();
    chk("rst_read.still_idle", N'(rsp_valid), '0);
    last_served = 1;
    txn("after_rst_addr7", 2'b01, 6'd7, 6'd0, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      txn($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)), 6'($urandom), 6'($urandom),
          int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
